chip8_frame_streamer: RTL and testbench

Reads the CHIP-8 64x32 monochrome framebuffer (the 2048-bit `display` vector produced by `chip8_top`) and serializes it into a byte stream for an external display link. On each `start` it snapshots the framebuffer so that later CPU draws cannot tear the frame. It then emits an optional header byte followed by 256 pixel bytes over a valid/ready handshake. It sits between `chip8_top.display` and the physical display transmitter (SPI/UART/LED driver).

---
 rtl/chip8_frame_streamer.sv | 118 +++++++++++
 tb/tb_chip8_frame_streamer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_frame_streamer.sv
// rtl/chip8_frame_streamer.sv - snapshots the CHIP-8 64x32 framebuffer and streams it as
// an optional sync byte plus 256 pixel bytes (MSB = leftmost pixel) over valid/ready.
module chip8_frame_streamer #(
  parameter bit         HEADER_EN = 1'b1,
  parameter logic [7:0] HEADER    = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2047:0] display,
  input  logic          start,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    k_q, k_d;
  logic [2047:0] snap_q;
  logic [2047:0] snap_src;
  logic          snap_load;
  logic          accept;
  logic [7:0]    pix_byte;

  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    snap_load = 1'b0;
    done_d    = 1'b0;
    accept    = valid_q & out_ready;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_load = 1'b1;
          k_d       = 8'd0;
          state_d   = HEADER_EN ? HDR : DATA;
        end
      end
      HDR: begin
        if (accept) state_d = DATA;
      end
      DATA: begin
        if (accept) begin
          if (k_q == 8'hFF) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // On the start edge the snapshot is still loading, so read the live framebuffer
  // to have pixel byte 0 ready in the very next cycle when the header is disabled.
  always_comb begin
    snap_src = snap_load ? display : snap_q;
    pix_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pix_byte[7-i] = snap_src[{k_d, 3'(i)}];
    end
  end

  // Outputs are registered from the next state, so they are stable while stalled.
  always_comb begin
    valid_d = (state_d != IDLE);
    data_d  = 8'h00;
    last_d  = 1'b0;
    if (state_d == HDR) begin
      data_d = HEADER;
    end else if (state_d == DATA) begin
      data_d = pix_byte;
      last_d = (k_d == 8'hFF);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= 8'd0;
      snap_q  <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (snap_load) snap_q <= display;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign busy       = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_chip8_frame_streamer.sv
// tb/tb_chip8_frame_streamer.sv - scoreboard bench for chip8_frame_streamer with and
// without the header byte.
module tb_chip8_frame_streamer;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2047:0] display = '0;
  logic          start1 = 1'b0;
  logic          start0 = 1'b0;
  logic          out_ready = 1'b0;

  logic [7:0] d1_data, d0_data;
  logic       d1_valid, d1_last, d1_busy, d1_done;
  logic       d0_valid, d0_last, d0_busy, d0_done;

  int checks = 0;
  int errors = 0;
  int acc1 = 0;
  int acc0 = 0;
  int last_at0 = 0;

  logic [8:0] exp1[$];
  logic [8:0] exp0[$];

  always #5 clk = ~clk;

  chip8_frame_streamer #(.HEADER_EN(1'b1), .HEADER(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .display(display), .start(start1), .out_ready(out_ready),
    .out_data(d1_data), .out_valid(d1_valid), .out_last(d1_last), .busy(d1_busy),
    .frame_done(d1_done)
  );

  chip8_frame_streamer #(.HEADER_EN(1'b0), .HEADER(8'hA5)) dut0 (
    .clk(clk), .reset(reset), .display(display), .start(start0), .out_ready(out_ready),
    .out_data(d0_data), .out_valid(d0_valid), .out_last(d0_last), .busy(d0_busy),
    .frame_done(d0_done)
  );

  function automatic logic [7:0] px_byte(input logic [2047:0] fb, input int k);
    int y, c;
    logic [7:0] b;
    y = k / 8;
    c = k % 8;
    for (int i = 0; i < 8; i++) b[7-i] = fb[y*64 + c*8 + i];
    return b;
  endfunction

  task automatic push_frame(input bit hdr, input logic [2047:0] fb);
    if (hdr) exp1.push_back({1'b0, 8'hA5});
    for (int k = 0; k < 256; k++) begin
      if (hdr) exp1.push_back({(k == 255), px_byte(fb, k)});
      else     exp0.push_back({(k == 255), px_byte(fb, k)});
    end
  endtask

  task automatic pulse_start(input bit hdr);
    @(posedge clk); #1;
    if (hdr) start1 = 1'b1;
    else     start0 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic wait_done(input bit hdr, input int max, output bit seen, output int n);
    seen = 1'b0;
    n = 0;
    for (int c = 0; c < max && !seen; c++) begin
      @(negedge clk);
      n = c + 1;
      if (hdr ? d1_done : d0_done) seen = 1'b1;
    end
  endtask

  // Stream monitor: pops the scoreboard on every accept and checks stall stability.
  initial begin
    logic       stall1, stall0;
    logic [8:0] held1, held0, e;
    stall1 = 1'b0;
    stall0 = 1'b0;
    held1 = '0;
    held0 = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall1 = 1'b0;
        stall0 = 1'b0;
      end else begin
        if (stall1) begin
          checks++;
          if (!d1_valid || {d1_last, d1_data} !== held1) begin
            errors++;
            $display("FAIL hold1 got valid=%b last/data=%h want valid=1 last/data=%h",
                     d1_valid, {d1_last, d1_data}, held1);
          end
        end
        if (stall0) begin
          checks++;
          if (!d0_valid || {d0_last, d0_data} !== held0) begin
            errors++;
            $display("FAIL hold0 got valid=%b last/data=%h want valid=1 last/data=%h",
                     d0_valid, {d0_last, d0_data}, held0);
          end
        end
        if (d1_valid && out_ready) begin
          acc1++;
          checks++;
          if (exp1.size() == 0) begin
            errors++;
            $display("FAIL extra1 got data=%h want no byte", d1_data);
          end else begin
            e = exp1.pop_front();
            if ({d1_last, d1_data} !== e) begin
              errors++;
              $display("FAIL stream1 got last/data=%h want %h", {d1_last, d1_data}, e);
            end
          end
        end
        if (d0_valid && out_ready) begin
          acc0++;
          if (d0_last) last_at0 = acc0;
          checks++;
          if (exp0.size() == 0) begin
            errors++;
            $display("FAIL extra0 got data=%h want no byte", d0_data);
          end else begin
            e = exp0.pop_front();
            if ({d0_last, d0_data} !== e) begin
              errors++;
              $display("FAIL stream0 got last/data=%h want %h", {d0_last, d0_data}, e);
            end
          end
        end
        stall1 = d1_valid && !out_ready;
        stall0 = d0_valid && !out_ready;
        held1 = {d1_last, d1_data};
        held0 = {d0_last, d0_data};
      end
    end
  end

  task automatic test_reset();
    #1 reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      start1 = 1'($urandom_range(0, 1));
      start0 = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      display = {64{$urandom()}};
      @(negedge clk);
      checks++;
      if ({d1_valid, d1_busy, d1_done, d1_last, d1_data, d0_valid, d0_busy, d0_done, d0_last, d0_data} !== 24'h0) begin
        errors++;
        $display("FAIL reset_hold got d1=%b%b%b%b/%h d0=%b%b%b%b/%h want all 0", d1_valid, d1_busy,
                 d1_done, d1_last, d1_data, d0_valid, d0_busy, d0_done, d0_last, d0_data);
      end
    end
    @(posedge clk); #1;
    start1 = 1'b0;
    start0 = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({d1_valid, d1_busy, d1_done, d1_last, d1_data, d0_valid, d0_busy, d0_done, d0_last, d0_data} !== 24'h0) begin
        errors++;
        $display("FAIL reset_release got d1 valid=%b data=%h d0 valid=%b data=%h want all 0",
                 d1_valid, d1_data, d0_valid, d0_data);
      end
    end
  endtask

  task automatic test_pixel_map();
    bit seen;
    int n, base;
    display = '0;
    display[0] = 1'b1;
    display[72] = 1'b1;
    display[2047] = 1'b1;
    out_ready = 1'b1;
    push_frame(1'b1, display);
    base = acc1;
    pulse_start(1'b1);
    @(negedge clk);
    checks++;
    if (!(d1_valid && d1_busy && d1_data == 8'hA5)) begin
      errors++;
      $display("FAIL pix_first got valid=%b busy=%b data=%h want 1 1 a5", d1_valid, d1_busy, d1_data);
    end
    wait_done(1'b1, 400, seen, n);
    checks++;
    if (!seen || n != 257) begin
      errors++;
      $display("FAIL pix_done_time got seen=%b cycles=%0d want 1 257", seen, n);
    end
    checks++;
    if ((acc1 - base) != 257 || d1_busy || d1_valid || exp1.size() != 0) begin
      errors++;
      $display("FAIL pix_count got accepts=%0d busy=%b valid=%b left=%0d want 257 0 0 0",
               acc1 - base, d1_busy, d1_valid, exp1.size());
    end
    @(negedge clk);
    checks++;
    if (d1_done !== 1'b0) begin
      errors++;
      $display("FAIL pix_done_pulse got %b want 0", d1_done);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int base;
    display = '1;
    out_ready = 1'b0;
    push_frame(1'b1, display);
    base = acc1;
    pulse_start(1'b1);
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (d1_done) seen = 1'b1;
    end
    out_ready = 1'b1;
    checks++;
    if (!seen || (acc1 - base) != 257 || exp1.size() != 0) begin
      errors++;
      $display("FAIL bp_count got seen=%b accepts=%0d left=%0d want 1 257 0", seen, acc1 - base, exp1.size());
    end
  endtask

  task automatic test_snapshot();
    bit seen;
    int n, base;
    display = '0;
    out_ready = 1'b1;
    push_frame(1'b1, display);
    base = acc1;
    pulse_start(1'b1);
    for (int c = 0; c < 100 && (acc1 - base) < 11; c++) @(negedge clk);
    checks++;
    if ((acc1 - base) < 11) begin
      errors++;
      $display("FAIL snap_progress got accepts=%0d want >=11", acc1 - base);
    end
    @(posedge clk); #1;
    display = '1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1'b1, 400, seen, n);
    checks++;
    if (!seen || (acc1 - base) != 257) begin
      errors++;
      $display("FAIL snap_count got seen=%b accepts=%0d want 1 257", seen, acc1 - base);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (d1_valid || d1_busy) begin
        errors++;
        $display("FAIL snap_restart got valid=%b busy=%b want 0 0", d1_valid, d1_busy);
      end
    end
  endtask

  task automatic test_midframe_reset_b2b();
    bit seen;
    int n, base;
    display = {64{$urandom()}};
    out_ready = 1'b1;
    push_frame(1'b1, display);
    base = acc1;
    pulse_start(1'b1);
    for (int c = 0; c < 200 && (acc1 - base) < 101; c++) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({d1_valid, d1_busy, d1_done, d1_last, d1_data} !== 12'h0) begin
      errors++;
      $display("FAIL mid_reset got valid=%b busy=%b done=%b last=%b data=%h want all 0",
               d1_valid, d1_busy, d1_done, d1_last, d1_data);
    end
    exp1.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (d1_valid || d1_busy) begin
        errors++;
        $display("FAIL mid_resume got valid=%b busy=%b want 0 0", d1_valid, d1_busy);
      end
    end
    push_frame(1'b1, display);
    base = acc1;
    pulse_start(1'b1);
    wait_done(1'b1, 400, seen, n);
    checks++;
    if (!seen || (acc1 - base) != 257) begin
      errors++;
      $display("FAIL b2b_first got seen=%b accepts=%0d want 1 257", seen, acc1 - base);
    end
    display = {64{$urandom()}};
    push_frame(1'b1, display);
    base = acc1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    checks++;
    if (!(d1_valid && d1_busy && d1_data == 8'hA5)) begin
      errors++;
      $display("FAIL b2b_header got valid=%b busy=%b data=%h want 1 1 a5", d1_valid, d1_busy, d1_data);
    end
    wait_done(1'b1, 400, seen, n);
    checks++;
    if (!seen || (acc1 - base) != 257 || exp1.size() != 0) begin
      errors++;
      $display("FAIL b2b_second got seen=%b accepts=%0d left=%0d want 1 257 0", seen, acc1 - base, exp1.size());
    end
  endtask

  task automatic test_no_header();
    bit seen;
    int n, base;
    display = '0;
    display[0] = 1'b1;
    display[72] = 1'b1;
    display[2047] = 1'b1;
    out_ready = 1'b1;
    push_frame(1'b0, display);
    base = acc0;
    pulse_start(1'b0);
    @(negedge clk);
    checks++;
    if (!(d0_valid && d0_busy && d0_data == 8'h80)) begin
      errors++;
      $display("FAIL nohdr_first got valid=%b busy=%b data=%h want 1 1 80", d0_valid, d0_busy, d0_data);
    end
    wait_done(1'b0, 400, seen, n);
    checks++;
    if (!seen || n != 256) begin
      errors++;
      $display("FAIL nohdr_done_time got seen=%b cycles=%0d want 1 256", seen, n);
    end
    checks++;
    if ((acc0 - base) != 256 || (last_at0 - base) != 256 || exp0.size() != 0) begin
      errors++;
      $display("FAIL nohdr_count got accepts=%0d last_at=%0d left=%0d want 256 256 0",
               acc0 - base, last_at0 - base, exp0.size());
    end
  endtask

  initial begin
    test_reset();
    test_pixel_map();
    test_backpressure();
    test_snapshot();
    test_midframe_reset_b2b();
    test_no_header();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
